popcount_stream: RTL and testbench

Sequential, parametrised population-count engine for multi-word bit vectors. It accepts WIDTH-bit words over a valid/ready stream and scans each word LANE bits per cycle. Per-word counts accumulate across words until a word tagged `in_last` closes the vector. The final count is presented on a backpressured output channel. It is the area-lean successor to the single-word 32-bit combinational popcount: arbitrary width and lane, multi-word accumulation, saturation reporting and handshakes.

---
 rtl/popcount_stream.sv | 103 ++++++++++
 tb/tb_popcount_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_stream.sv
// Sequential population counter: scans each accepted word LANE bits per cycle and
// accumulates a saturating count across words until a last-tagged word closes the vector.
module popcount_stream #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam int N      = WIDTH / LANE;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [BEAT_W-1:0]  r_beat;
    logic               r_last;
    logic [CNT_W-1:0]   r_acc;
    logic               r_sat;

    logic [CNT_W:0]     w_lanePop;
    logic [CNT_W:0]     w_sum;
    logic [WIDTH-1:0]   w_shNext;

    always_comb begin
        w_lanePop = '0;
        for (int i = 0; i < LANE; i++) begin
            w_lanePop = w_lanePop + {{CNT_W{1'b0}}, r_shreg[i]};
        end
    end

    // One extra bit of headroom so an overflowing add is visible in the carry.
    assign w_sum = {1'b0, r_acc} + w_lanePop;

    generate
        if (N > 1) begin : g_shift
            assign w_shNext = {{LANE{1'b0}}, r_shreg[WIDTH-1:LANE]};
        end else begin : g_noShift
            assign w_shNext = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_beat  <= '0;
            r_last  <= 1'b0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shreg <= in_data;
                        r_beat  <= BEAT_W'(N - 1);
                        r_last  <= in_last;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_sum[CNT_W]) begin
                        r_acc <= '1;
                        r_sat <= 1'b1;
                    end else begin
                        r_acc <= w_sum[CNT_W-1:0];
                    end
                    r_shreg <= w_shNext;
                    r_beat  <= r_beat - 1'b1;
                    // A non-last word keeps the accumulator so the next word adds onto it.
                    if (r_beat == '0) begin
                        r_state <= r_last ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_sat   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign out_count = r_acc;
    assign out_sat   = r_sat;

endmodule

// File: tb/tb_popcount_stream.sv
// Scoreboard bench for popcount_stream across several WIDTH/LANE/CNT_W configurations.
module tb_popcount_stream;

    typedef struct {
        longint count;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             inValid  [5];
    logic             inLast   [5];
    logic             outReady [5];
    logic [63:0]      inData   [5];
    logic [4:0]       inReady;
    logic [4:0]       outValid;
    logic [4:0]       outSat;
    logic [4:0][15:0] outCount;

    int nBeats [5] = '{4, 4, 32, 1, 8};
    int cntW   [5] = '{16, 6, 16, 16, 16};
    int wordW  [5] = '{32, 32, 32, 32, 64};

    int     assertCount = 0;
    int     failCount   = 0;
    longint runTotal    = 0;
    bit     randOn      = 1'b0;
    exp_t   expQ[$];

    popcount_stream #(.WIDTH(32), .LANE(8), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_data(inData[0][31:0]), .in_last(inLast[0]), .out_valid(outValid[0]),
        .out_ready(outReady[0]), .out_count(outCount[0]), .out_sat(outSat[0]));

    popcount_stream #(.WIDTH(32), .LANE(8), .CNT_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_data(inData[1][31:0]), .in_last(inLast[1]), .out_valid(outValid[1]),
        .out_ready(outReady[1]), .out_count(outCount[1][5:0]), .out_sat(outSat[1]));
    assign outCount[1][15:6] = '0;

    popcount_stream #(.WIDTH(32), .LANE(1), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_data(inData[2][31:0]), .in_last(inLast[2]), .out_valid(outValid[2]),
        .out_ready(outReady[2]), .out_count(outCount[2]), .out_sat(outSat[2]));

    popcount_stream #(.WIDTH(32), .LANE(32), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[3]), .in_ready(inReady[3]),
        .in_data(inData[3][31:0]), .in_last(inLast[3]), .out_valid(outValid[3]),
        .out_ready(outReady[3]), .out_count(outCount[3]), .out_sat(outSat[3]));

    popcount_stream #(.WIDTH(64), .LANE(8), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[4]), .in_ready(inReady[4]),
        .in_data(inData[4]), .in_last(inLast[4]), .out_valid(outValid[4]),
        .out_ready(outReady[4]), .out_count(outCount[4]), .out_sat(outSat[4]));

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one word, updates the reference total and checks per-word latency.
    task automatic applyStimulus(input int k, input logic [63:0] data, input logic last);
        int     waitCyc = 0;
        int     lat;
        longint maxV;
        exp_t   e;
        while (!inReady[k] && waitCyc < 300) begin
            tick();
            waitCyc++;
        end
        if (!inReady[k]) begin
            checkOutput($sformatf("acceptTimeout[%0d]", k), 0, 1);
            return;
        end
        inValid[k] = 1'b1;
        inData[k]  = data;
        inLast[k]  = last;
        runTotal += $countones((wordW[k] == 64) ? data : {32'h0, data[31:0]});
        if (last) begin
            maxV    = (longint'(1) << cntW[k]) - 1;
            e.count = (runTotal > maxV) ? maxV : runTotal;
            e.sat   = (runTotal > maxV);
            expQ.push_back(e);
            runTotal = 0;
        end
        tick();
        inValid[k] = 1'b0;
        inData[k]  = {$urandom, $urandom};
        lat = 1;
        while (!(inReady[k] || outValid[k]) && lat < 200) begin
            tick();
            lat++;
        end
        checkOutput($sformatf("latency[%0d]", k), lat, nBeats[k] + 1);
        if (!last) checkOutput($sformatf("noMidValid[%0d]", k), outValid[k], 0);
    endtask

    task automatic drain(input int k);
        int n = 0;
        while ((expQ.size() != 0 || outValid[k]) && n < 300) begin
            tick();
            n++;
        end
        checkOutput($sformatf("drain[%0d]", k), expQ.size(), 0);
    endtask

    // Results are compared at the moment the handshake is about to complete.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (rst_n && outValid[k] && outReady[k]) begin
                if (expQ.size() == 0) begin
                    checkOutput($sformatf("unexpectedResult[%0d]", k), 1, 0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput($sformatf("count[%0d]", k), outCount[k], e.count);
                    checkOutput($sformatf("sat[%0d]", k), outSat[k], e.sat);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randOn) begin
                for (int k = 2; k < 5; k++) outReady[k] = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        for (int k = 0; k < 5; k++) begin
            inValid[k]  = 1'b0;
            inLast[k]   = 1'b0;
            inData[k]   = '0;
            outReady[k] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("rstInReady[%0d]", k), inReady[k], 1);
            checkOutput($sformatf("rstOutValid[%0d]", k), outValid[k], 0);
        end
        checkOutput("rstCount", outCount[0], 0);
        checkOutput("rstSat", outSat[0], 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] all-ones single word");
        applyStimulus(0, 64'hFFFF_FFFF, 1'b1);
        drain(0);

        $display("[TB] two-word vector");
        applyStimulus(0, 64'h8000_0001, 1'b0);
        applyStimulus(0, 64'h0000_00F0, 1'b1);
        drain(0);

        $display("[TB] result held under backpressure");
        outReady[0] = 1'b0;
        applyStimulus(0, 64'h0F0F_0F0F, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("holdValid", outValid[0], 1);
            checkOutput("holdCount", outCount[0], 16);
            checkOutput("holdInReady", inReady[0], 0);
            if (i == 4) begin
                inValid[0] = 1'b1;
                inData[0]  = 64'hFFFF_FFFF;
                inLast[0]  = 1'b1;
            end else begin
                inValid[0] = 1'b0;
            end
            tick();
        end
        inValid[0]  = 1'b0;
        outReady[0] = 1'b1;
        tick();
        checkOutput("releaseValid", outValid[0], 0);
        checkOutput("releaseInReady", inReady[0], 1);
        drain(0);
        applyStimulus(0, 64'h0, 1'b1);
        drain(0);

        $display("[TB] saturation with CNT_W=6");
        applyStimulus(1, 64'hFFFF_FFFF, 1'b0);
        applyStimulus(1, 64'hFFFF_FFFF, 1'b1);
        drain(1);
        applyStimulus(1, 64'h3, 1'b1);
        drain(1);

        $display("[TB] reset during scan");
        inValid[0] = 1'b1;
        inData[0]  = 64'hFFFF_FFFF;
        inLast[0]  = 1'b1;
        tick();
        inValid[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("midRstInReady", inReady[0], 1);
        checkOutput("midRstOutValid", outValid[0], 0);
        checkOutput("midRstCount", outCount[0], 0);
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 64'h0000_000F, 1'b1);
        drain(0);

        $display("[TB] random sweep");
        randOn = 1'b1;
        for (int k = 2; k < 5; k++) begin
            for (int v = 0; v < 6; v++) begin
                len = $urandom_range(1, 8);
                for (int w = 0; w < len; w++) begin
                    applyStimulus(k, {$urandom, $urandom}, (w == len - 1));
                end
            end
            drain(k);
        end
        randOn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
